key_debounce_bank: RTL

//  N-channel input conditioner for the snake game: KEY[3:0] direction buttons plus the SW[9] reset switch.

---
 rtl/snake_io_pkg.sv | 25 ++
 rtl/key_debounce_bank_if.sv | 30 +++
 rtl/debounce_channel.sv | 148 ++++++++++++++
 rtl/key_debounce_bank.sv | 51 +++++
 4 files changed

// File: rtl/snake_io_pkg.sv
// Shared types and constants for the snake game input path.
//   rep_state_t : per-channel auto-repeat state
//   CH_*        : channel index of each button in the key_debounce_bank
//   CLK_HZ      : system clock frequency the default timings are derived from
package snake_io_pkg;

  typedef enum logic [1:0] {
    REP_IDLE   = 2'd0,
    REP_DELAY  = 2'd1,
    REP_PERIOD = 2'd2
  } rep_state_t;

  localparam int CH_RIGHT = 0;
  localparam int CH_DOWN  = 1;
  localparam int CH_UP    = 2;
  localparam int CH_LEFT  = 3;
  localparam int CH_RESET = 4;

  localparam int CLK_HZ = 50_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_bank_if.sv
// Bundle between the pad side (master: drives clear/raw_in) and the
// key_debounce_bank (slave: returns conditioned levels and pulses).
//   clear         : synchronous soft clear of all channels
//   raw_in        : raw pad inputs, asynchronous to clk
//   level_out     : debounced, polarity-corrected level
//   press         : 1-cycle pulse on debounced 0->1
//   release_pulse : 1-cycle pulse on debounced 1->0 ("release" is a reserved word)
//   act           : press or auto-repeat pulse
//   any_level     : OR of level_out
interface key_debounce_bank_if #(
  parameter int N_CH = 5
);
  logic            clear;
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] level_out;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] act;
  logic            any_level;

  modport master (
    output clear, raw_in,
    input  level_out, press, release_pulse, act, any_level
  );

  modport slave (
    input  clear, raw_in,
    output level_out, press, release_pulse, act, any_level
  );
endinterface

// File: rtl/debounce_channel.sv
// One input channel: polarity correction, 2-FF synchronizer, stability-count
// debounce, registered press/release pulses and optional auto-repeat.
// Ports:
//   clk, rst_flag  : clock, asynchronous active-high reset
//   clear          : synchronous clear of level, counters and repeat state
//   raw            : raw pad input
//   level          : debounced level (active-high)
//   press          : 1-cycle pulse, first cycle level shows 1
//   release_pulse  : 1-cycle pulse, first cycle level shows 0
//   act            : press | repeat pulse
//
// Repeat FSM:
//   state      | meaning
//   REP_IDLE   | key not held (or repeat disabled)
//   REP_DELAY  | held, counting the initial delay to the first repeat
//   REP_PERIOD | held, emitting a repeat every REPEAT_PERIOD cycles
module debounce_channel
  import snake_io_pkg::*;
#(
  parameter int STABLE_CYCLES = 500_000,
  parameter bit INVERT        = 1'b0,
  parameter bit REP_ON        = 1'b0,
  parameter int REPEAT_DELAY  = 15_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst_flag,
  input  logic clear,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic act
);

  localparam int CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;
  rep_state_t    rstate;
  logic [RW-1:0] rcnt;
  logic          rep;

  logic flip;
  logic rise;
  logic fall;

  // flip: the mismatch has lasted STABLE_CYCLES cycles, level takes sync_b now
  assign flip = (sync_b != level) && (cnt == CNT_LAST);
  assign rise = flip & sync_b;
  assign fall = flip & ~sync_b;

  // Synchronizer is intentionally not affected by clear.
  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw ^ INVERT;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      level         <= 1'b0;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else if (clear) begin
      // Forced low without a release pulse; a held key re-debounces.
      level         <= 1'b0;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= rise;
      release_pulse <= fall;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      rstate <= REP_IDLE;
      rcnt   <= '0;
      rep    <= 1'b0;
    end else if (clear || !REP_ON) begin
      rstate <= REP_IDLE;
      rcnt   <= '0;
      rep    <= 1'b0;
    end else begin
      rep <= 1'b0;
      case (rstate)
        REP_IDLE: begin
          if (rise) begin
            rstate <= REP_DELAY;
            rcnt   <= '0;
          end
        end
        REP_DELAY: begin
          if (fall) begin
            rstate <= REP_IDLE;
            rcnt   <= '0;
          end else if (rcnt == DLY_LAST) begin
            rep    <= 1'b1;
            rcnt   <= '0;
            rstate <= REP_PERIOD;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        REP_PERIOD: begin
          if (fall) begin
            rstate <= REP_IDLE;
            rcnt   <= '0;
          end else if (rcnt == PER_LAST) begin
            rep  <= 1'b1;
            rcnt <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: begin
          rstate <= REP_IDLE;
          rcnt   <= '0;
        end
      endcase
    end
  end

  assign act = press | rep;

endmodule

// File: rtl/key_debounce_bank.sv
// N-channel input conditioner for the snake game: KEY[3:0] direction buttons
// plus the SW[9] reset switch. Each channel is an independent debounce_channel.
// Ports:
//   clk, rst_flag : clock, asynchronous active-high reset
//   bus           : key_debounce_bank_if slave (clear/raw_in in; levels, pulses out)
module key_debounce_bank
  import snake_io_pkg::*;
#(
  parameter int              N_CH          = 5,
  parameter int              STABLE_CYCLES = CLK_HZ / 100,
  parameter logic [N_CH-1:0] ACTIVE_LOW    = 5'b01111,
  parameter logic [N_CH-1:0] REPEAT_EN     = 5'b01111,
  parameter int              REPEAT_DELAY  = 15_000_000,
  parameter int              REPEAT_PERIOD = 5_000_000
) (
  input logic              clk,
  input logic              rst_flag,
  key_debounce_bank_if.slave bus
);

  logic [N_CH-1:0] level_v;
  logic [N_CH-1:0] press_v;
  logic [N_CH-1:0] release_v;
  logic [N_CH-1:0] act_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .INVERT        (ACTIVE_LOW[i]),
      .REP_ON        (REPEAT_EN[i]),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .rst_flag      (rst_flag),
      .clear         (bus.clear),
      .raw           (bus.raw_in[i]),
      .level         (level_v[i]),
      .press         (press_v[i]),
      .release_pulse (release_v[i]),
      .act           (act_v[i])
    );
  end

  assign bus.level_out     = level_v;
  assign bus.press         = press_v;
  assign bus.release_pulse = release_v;
  assign bus.act           = act_v;
  assign bus.any_level     = |level_v;

endmodule
